imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the pipelined MIPS core. It loads a program over a byte-serial load port, releases the core by raising its chip enable, then answers the core's fetch requests. Each fetch address (PC) is answered with one registered instruction word per cycle. It sits between the test/boot host and the processor top: `im_o_ce` drives the core's `p_i_ce` and `im_i_pc` is driven from the core's `p_o_pc`.

## Interface
Parameters:
- `IWIDTH`, 32: instruction word width; the byte assembly is fixed at 4 bytes per word.
- `PC_WIDTH`, 32: width of the fetch address.
- `DEPTH`, 5: word-address bits; the memory holds 2^DEPTH words.

Ports:
- `im_clk`  in  1: single clock; all state changes on its rising edge.
- `im_rst`  in  1: synchronous, active-high reset.
- `im_i_ld_valid`  in  1: load byte strobe.
- `im_i_ld_byte`  in  8: load byte.
- `im_i_ld_last`  in  1: qualifies the final byte of the program.
- `im_o_ld_ready`  out  1: load byte accepted when `valid & ready`.
- `im_o_ce`  out  1: core enable, connected to `p_i_ce`.
- `im_i_pc`  in  PC_WIDTH: fetch byte address from the core.
- `im_o_instr`  out  IWIDTH: fetched instruction.
- `im_o_instr_valid`  out  1: `im_o_instr` is a RUN-state response.
- `im_o_words`  out  DEPTH+1: number of words loaded.
- `im_o_err`  out  1: sticky error flag.

## Operation
- States are LOAD, RUN and ERR. Reset enters LOAD.
- Reset values: `ld_ready`=0 while `im_rst` is high, `ce`=0, `instr`=0, `instr_valid`=0, `err`=0, `words`=0, byte counter=0, write pointer=0. Memory contents are not cleared.
- **LOAD:**
  - `ld_ready`=1 and `ce`=0.
  - Accepted bytes are assembled big-endian: the first byte goes to [31:24] and the fourth to [7:0].
  - On the 4th accepted byte the word is written to `mem[wptr]`, then `wptr` and `words` each increment by 1.
  - If `ld_last` accompanies the 4th byte → RUN.
  - If `ld_last` accompanies byte 1–3 (partial word) → ERR; no write occurs.
  - If the 2^DEPTH-th word is written without `ld_last` (overflow) → ERR. That word is still written and counted.
- **RUN:**
  - `ld_ready`=0 and `ce`=1. Load strobes are ignored.
  - Each cycle the block registers a response for `im_i_pc`, using word index `pc[DEPTH+1:2]`:
    - If all PC bits above DEPTH+1 are zero and the index < `words`, `instr` = `mem[index]`.
    - Otherwise `instr` = 32'h0000_0000 (NOP). This is not an error.
  - `instr_valid`=1 on every response.
  - If `pc[1:0]`≠0 → ERR. The response for that cycle is NOP with `instr_valid`=0.
- **ERR:**
  - `ce`=0, `ld_ready`=0, `err`=1, `instr_valid`=0, `instr` holds its last value.
  - Only `im_rst` exits ERR.
- Reset mid-operation, in any state, returns to LOAD with all counters zero. Old memory words are unreachable because `words`=0.
- Arithmetic: `words` saturates naturally at 2^DEPTH because that count forces RUN or ERR. `wptr` is DEPTH bits wide and never wraps, since the overflow check fires first.

## Timing
- A load byte is consumed in the cycle `valid & ready` is high. The word write lands on the same edge as the 4th byte, so a read of that word is possible from the next cycle.
- LOAD→RUN: `ce` rises in the cycle after the edge that accepted the last byte. The first response follows one cycle after `ce` rises.
- Fetch latency is exactly 1 cycle: the PC sampled at edge t appears on `im_o_instr` after edge t, stable through cycle t+1. There are no back-pressure or wait states.
- Entry into ERR (misalign or partial/overflow load) drops `ce` and raises `err` in the cycle after the offending edge.

## Structure
- A shared package/header holds the state encodings (LOAD=2'd0, RUN=2'd1, ERR=2'd2), the NOP constant 32'h0, and BYTES_PER_WORD=4.
- One natural sub-module, `imem_ram`: a 2^DEPTH×IWIDTH single-write, single-read synchronous RAM with a registered read port.
- The top of the block holds the FSM, byte assembler, counters and range/alignment checks.

## Test plan
- Load 8 bytes 20 08 00 05 / 01 09 50 20 with `last` on byte 8 → `words`=2, `ce` rises next cycle; pc=0 → 32'h2008_0005, pc=4 → 32'h0109_5020, each one cycle later.
- After a 2-word load, pc=8 and pc=32'h8000_0000 → `instr`=0 with `instr_valid`=1, `err`=0.
- In RUN, pc=6 → `err`=1 and `ce`=0 next cycle; these persist until `im_rst`, after which `ld_ready`=1 and `words`=0.
- Load 6 bytes with `last` on byte 6 → ERR, `words`=1, `ce` never rises.
- DEPTH=2: load 16 bytes without `last` → `words`=4, ERR; the same load with `last` on byte 16 → RUN, and pc=12 returns word 3.
- Assert `im_rst` for 1 cycle mid-load after 5 bytes, then load 4 bytes with `last` → `words`=1 and pc=0 returns the new word.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared encodings for the instruction-memory responder: FSM states,
// the NOP word and the fixed byte-to-word packing.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [31:0] NOP            = 32'h0000_0000;
  localparam int          BYTES_PER_WORD = 4;
  localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_responder_if.sv
// Load-port and fetch-port bundle between the boot host / core (master)
// and the instruction-memory responder (slave).
interface imem_responder_if #(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 5
);

  logic                im_i_ld_valid;
  logic [7:0]          im_i_ld_byte;
  logic                im_i_ld_last;
  logic                im_o_ld_ready;
  logic                im_o_ce;
  logic [PC_WIDTH-1:0] im_i_pc;
  logic [IWIDTH-1:0]   im_o_instr;
  logic                im_o_instr_valid;
  logic [DEPTH:0]      im_o_words;
  logic                im_o_err;

  modport slave (
    input  im_i_ld_valid, im_i_ld_byte, im_i_ld_last, im_i_pc,
    output im_o_ld_ready, im_o_ce, im_o_instr, im_o_instr_valid,
           im_o_words, im_o_err
  );

  modport master (
    output im_i_ld_valid, im_i_ld_byte, im_i_ld_last, im_i_pc,
    input  im_o_ld_ready, im_o_ce, im_o_instr, im_o_instr_valid,
           im_o_words, im_o_err
  );

endinterface

// File: rtl/imem_ram.sv
// Single-write, single-read synchronous RAM with a registered read port.
// Contents are never cleared; the responder gates stale words by count.
module imem_ram #(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 5
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [DEPTH-1:0]  i_waddr,
  input  logic [IWIDTH-1:0] i_wdata,
  input  logic [DEPTH-1:0]  i_raddr,
  output logic [IWIDTH-1:0] o_rdata
);

  logic [IWIDTH-1:0] r_mem [0:(1<<DEPTH)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: assembles a byte-serial program into words,
// then releases the core and answers each fetch PC one cycle later.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int IWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 5
) (
  input  logic            im_clk,
  input  logic            im_rst,
  imem_responder_if.slave im_bus
);

  localparam logic [DEPTH:0]   ONE_WORD = (DEPTH+1)'(1);
  localparam logic [DEPTH-1:0] ONE_PTR  = DEPTH'(1);

  state_e            r_state;
  state_e            w_next_state;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_word_buf;
  logic [DEPTH-1:0]  r_wptr;
  logic [DEPTH:0]    r_words;
  logic              r_rd_hit;
  logic              r_instr_valid;
  logic [IWIDTH-1:0] r_instr_q;

  logic              w_ld_ready;
  logic              w_ce;
  logic              w_err;
  logic              w_accept;
  logic              w_word_done;
  logic              w_partial;
  logic              w_full;
  logic              w_misalign;
  logic              w_upper_zero;
  logic              w_hit;
  logic [DEPTH-1:0]  w_idx;
  logic [IWIDTH-1:0] w_wdata;
  logic [IWIDTH-1:0] w_rdata;
  logic [IWIDTH-1:0] w_instr;

  assign w_ld_ready   = (r_state == ST_LOAD) && !im_rst;
  assign w_accept     = im_bus.im_i_ld_valid && w_ld_ready;
  assign w_word_done  = w_accept && (r_byte_cnt == LAST_BYTE_IDX);
  assign w_partial    = w_accept && im_bus.im_i_ld_last && (r_byte_cnt != LAST_BYTE_IDX);
  assign w_full       = &r_wptr;
  assign w_wdata      = {r_word_buf, im_bus.im_i_ld_byte};

  assign w_misalign   = |im_bus.im_i_pc[1:0];
  assign w_idx        = im_bus.im_i_pc[DEPTH+1:2];
  assign w_upper_zero = (im_bus.im_i_pc[PC_WIDTH-1:DEPTH+2] == '0);
  assign w_hit        = w_upper_zero && ({1'b0, w_idx} < r_words);

  // Hits come straight from the RAM read register; misses and held values come from r_instr_q.
  assign w_instr      = r_rd_hit ? w_rdata : r_instr_q;

  imem_ram #(
    .IWIDTH (IWIDTH),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk   (im_clk),
    .i_we    (w_word_done),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge im_clk) begin
    if (im_rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ce         = 1'b0;
    w_err        = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        if (w_partial) begin
          w_next_state = ST_ERR;
        end else if (w_word_done && im_bus.im_i_ld_last) begin
          w_next_state = ST_RUN;
        end else if (w_word_done && w_full) begin
          w_next_state = ST_ERR;
        end
      end
      ST_RUN: begin
        w_ce = 1'b1;
        if (w_misalign) begin
          w_next_state = ST_ERR;
        end
      end
      ST_ERR: begin
        w_err = 1'b1;
      end
      default: begin
        w_next_state = ST_LOAD;
      end
    endcase
  end

  // The last word slot leaves wptr in place since that write always ends loading.
  always_ff @(posedge im_clk) begin
    if (im_rst) begin
      r_byte_cnt    <= '0;
      r_word_buf    <= '0;
      r_wptr        <= '0;
      r_words       <= '0;
      r_rd_hit      <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr_q     <= NOP;
    end else begin
      if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_word_buf <= {r_word_buf[15:0], im_bus.im_i_ld_byte};
      end
      if (w_word_done) begin
        r_words <= r_words + ONE_WORD;
        if (!w_full) begin
          r_wptr <= r_wptr + ONE_PTR;
        end
      end
      if (r_state == ST_RUN) begin
        r_instr_valid <= !w_misalign;
        r_rd_hit      <= w_hit && !w_misalign;
        r_instr_q     <= NOP;
      end else begin
        r_instr_valid <= 1'b0;
        r_rd_hit      <= 1'b0;
        r_instr_q     <= w_instr;
      end
    end
  end

  assign im_bus.im_o_ld_ready    = w_ld_ready;
  assign im_bus.im_o_ce          = w_ce;
  assign im_bus.im_o_err         = w_err;
  assign im_bus.im_o_instr       = w_instr;
  assign im_bus.im_o_instr_valid = r_instr_valid;
  assign im_bus.im_o_words       = r_words;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: one DEPTH=5 and one DEPTH=2 instance
// share the stimulus; the idle instance is held in reset.
module tb_imem_responder;

  logic        clk;
  logic        rst5;
  logic        rst2;
  logic        sel;
  logic        ldValid;
  logic [7:0]  ldByte;
  logic        ldLast;
  logic [31:0] pcIn;

  int checks;
  int failures;

  logic [31:0] q5[$];
  logic [31:0] q2[$];

  logic [31:0] outWords;
  logic [31:0] outInstr;
  logic        outValid;
  logic        outCe;
  logic        outErr;
  logic        outLdReady;

  logic [7:0]  prog [8];
  logic [7:0]  partialProg [6];
  logic [7:0]  newWord [4];

  imem_responder_if #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(5)) if5 ();
  imem_responder_if #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(2)) if2 ();

  assign if5.im_i_ld_valid = ldValid;
  assign if5.im_i_ld_byte  = ldByte;
  assign if5.im_i_ld_last  = ldLast;
  assign if5.im_i_pc       = pcIn;
  assign if2.im_i_ld_valid = ldValid;
  assign if2.im_i_ld_byte  = ldByte;
  assign if2.im_i_ld_last  = ldLast;
  assign if2.im_i_pc       = pcIn;

  imem_responder #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(5)) dut5 (
    .im_clk (clk),
    .im_rst (rst5),
    .im_bus (if5)
  );

  imem_responder #(.IWIDTH(32), .PC_WIDTH(32), .DEPTH(2)) dut2 (
    .im_clk (clk),
    .im_rst (rst2),
    .im_bus (if2)
  );

  assign outWords   = sel ? {29'b0, if2.im_o_words} : {26'b0, if5.im_o_words};
  assign outInstr   = sel ? if2.im_o_instr       : if5.im_o_instr;
  assign outValid   = sel ? if2.im_o_instr_valid : if5.im_o_instr_valid;
  assign outCe      = sel ? if2.im_o_ce          : if5.im_o_ce;
  assign outErr     = sel ? if2.im_o_err         : if5.im_o_err;
  assign outLdReady = sel ? if2.im_o_ld_ready    : if5.im_o_ld_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic last);
    ldValid = 1'b1;
    ldByte  = b;
    ldLast  = last;
    @(negedge clk);
    ldValid = 1'b0;
    ldLast  = 1'b0;
  endtask

  task automatic fetchPc(input logic [31:0] pc, input logic [31:0] expInstr, input logic expValid);
    pcIn = pc;
    if (expValid) begin
      if (sel) q2.push_back(expInstr);
      else     q5.push_back(expInstr);
    end
    @(negedge clk);
    checkOutput("instr_valid", {31'b0, outValid}, {31'b0, expValid});
    if (!expValid) checkOutput("misalign nop", outInstr, 32'h0);
  endtask

  task automatic doReset();
    if (sel) rst2 = 1'b1;
    else     rst5 = 1'b1;
    @(negedge clk);
    checkOutput("ld_ready in reset", {31'b0, outLdReady}, 32'd0);
    if (sel) rst2 = 1'b0;
    else     rst5 = 1'b0;
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (if5.im_o_instr_valid === 1'b1) begin
      if (q5.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL fetch5 unexpected response: got %h, expected none", if5.im_o_instr);
      end else begin
        checkOutput("fetch5", if5.im_o_instr, q5.pop_front());
      end
    end
    if (if2.im_o_instr_valid === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL fetch2 unexpected response: got %h, expected none", if2.im_o_instr);
      end else begin
        checkOutput("fetch2", if2.im_o_instr, q2.pop_front());
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    sel      = 1'b0;
    rst5     = 1'b1;
    rst2     = 1'b1;
    ldValid  = 1'b0;
    ldByte   = 8'h00;
    ldLast   = 1'b0;
    pcIn     = 32'h0;
    prog        = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    partialProg = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    newWord     = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    @(negedge clk);
    checkOutput("reset ld_ready", {31'b0, outLdReady}, 32'd0);
    checkOutput("reset ce",       {31'b0, outCe},      32'd0);
    checkOutput("reset err",      {31'b0, outErr},     32'd0);
    checkOutput("reset valid",    {31'b0, outValid},   32'd0);
    checkOutput("reset instr",    outInstr,            32'h0);
    checkOutput("reset words",    outWords,            32'd0);
    rst5 = 1'b0;
    #1;
    checkOutput("load ld_ready", {31'b0, outLdReady}, 32'd1);

    // Two-word program, then in-range, out-of-range and misaligned fetches.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(prog[i], i == 7);
      if (i == 6) checkOutput("ce before last", {31'b0, outCe}, 32'd0);
    end
    checkOutput("words after 8 bytes", outWords, 32'd2);
    checkOutput("ce after last", {31'b0, outCe}, 32'd1);
    checkOutput("ld_ready in run", {31'b0, outLdReady}, 32'd0);
    fetchPc(32'h0000_0000, 32'h2008_0005, 1'b1);
    fetchPc(32'h0000_0004, 32'h0109_5020, 1'b1);
    fetchPc(32'h0000_0008, 32'h0000_0000, 1'b1);
    fetchPc(32'h8000_0000, 32'h0000_0000, 1'b1);
    checkOutput("err after nop fetches", {31'b0, outErr}, 32'd0);
    fetchPc(32'h0000_000C, 32'h0000_0000, 1'b1);
    fetchPc(32'h0000_0006, 32'h0000_0000, 1'b0);
    checkOutput("misalign err", {31'b0, outErr}, 32'd1);
    checkOutput("misalign ce",  {31'b0, outCe},  32'd0);
    applyStimulus(8'h55, 1'b1);
    checkOutput("err sticky", {31'b0, outErr}, 32'd1);
    checkOutput("ce stays low", {31'b0, outCe}, 32'd0);
    checkOutput("words frozen in err", outWords, 32'd2);
    checkOutput("ld_ready in err", {31'b0, outLdReady}, 32'd0);
    doReset();
    checkOutput("post-reset ld_ready", {31'b0, outLdReady}, 32'd1);
    checkOutput("post-reset words", outWords, 32'd0);
    checkOutput("post-reset err", {31'b0, outErr}, 32'd0);

    // Partial final word.
    for (int i = 0; i < 6; i++) applyStimulus(partialProg[i], i == 5);
    checkOutput("partial err", {31'b0, outErr}, 32'd1);
    checkOutput("partial words", outWords, 32'd1);
    checkOutput("partial ce", {31'b0, outCe}, 32'd0);
    @(negedge clk);
    checkOutput("partial ce later", {31'b0, outCe}, 32'd0);
    doReset();

    // Reset in the middle of a load discards the count.
    for (int i = 0; i < 5; i++) applyStimulus(8'(i + 1), 1'b0);
    checkOutput("words before mid reset", outWords, 32'd1);
    doReset();
    checkOutput("words after mid reset", outWords, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(newWord[i], i == 3);
    checkOutput("reload words", outWords, 32'd1);
    checkOutput("reload ce", {31'b0, outCe}, 32'd1);
    fetchPc(32'h0000_0000, 32'hDEAD_BEEF, 1'b1);
    fetchPc(32'h0000_0004, 32'h0000_0000, 1'b1);
    doReset();
    rst5 = 1'b1;

    // DEPTH=2 instance: overflow without last, then a full load with last.
    sel  = 1'b1;
    rst2 = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus({4'(i % 4 + 1), 4'(i / 4)}, 1'b0);
      if (i == 14) begin
        checkOutput("d2 words at 15 bytes", outWords, 32'd3);
        checkOutput("d2 err at 15 bytes", {31'b0, outErr}, 32'd0);
      end
    end
    checkOutput("d2 overflow words", outWords, 32'd4);
    checkOutput("d2 overflow err", {31'b0, outErr}, 32'd1);
    checkOutput("d2 overflow ce", {31'b0, outCe}, 32'd0);
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus({4'(i % 4 + 1), 4'(i / 4)}, i == 15);
    checkOutput("d2 full words", outWords, 32'd4);
    checkOutput("d2 full ce", {31'b0, outCe}, 32'd1);
    checkOutput("d2 full err", {31'b0, outErr}, 32'd0);
    fetchPc(32'h0000_000C, 32'h1323_3343, 1'b1);
    fetchPc(32'h0000_0000, 32'h1020_3040, 1'b1);
    fetchPc(32'h0000_0010, 32'h0000_0000, 1'b1);
    fetchPc(32'h0000_0001, 32'h0000_0000, 1'b0);
    checkOutput("d2 misalign err", {31'b0, outErr}, 32'd1);

    @(negedge clk);
    checkOutput("q5 drained", q5.size(), 32'd0);
    checkOutput("q2 drained", q2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
